rnn_seq_ctrl: RTL and testbench

Sequencer that drives the `rnn` accelerator's register port so the host does not have to. Host software streams per-character embedding elements into a small FIFO. The controller writes each character's input vector and starts the recurrent step. After the last character of a sequence, it triggers the dense layer, fetches the 16-bit result and presents it on a valid/ready output. It sits between the host bus bridge and `rnn`, and owns `rnn`'s read/write/addr/data_in exclusively.

---
 rtl/rnn_seq_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_rnn_seq_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_seq_ctrl.sv
// Streams host embedding elements into the rnn register port, steps each character and fetches the dense result.
// rnn_* are decoded from state in the same cycle; s_ready = element FIFO not full; res_valid holds until res_ready.

module rnn_seq_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module rnn_seq_ctrl #(
  parameter int EMB_LEN    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [15:0] char_cnt,
  output logic        err,
  input  logic        clr_err,
  output logic        rnn_read,
  output logic        rnn_write,
  output logic [2:0]  rnn_addr,
  output logic [31:0] rnn_wdata,
  input  logic [31:0] rnn_rdata
);
  localparam int            PW       = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam logic [7:0]    LAST_IDX = 8'(EMB_LEN - 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_ELEM, S_START, S_WAIT_STEP, S_DENSE,
    S_WAIT_RES, S_READ_RES, S_HOLD_RES, S_ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    elem_idx, elem_idx_nxt;
  logic          seq_end, seq_end_nxt;
  logic [PW-1:0] poll_cnt, poll_cnt_nxt;
  logic [15:0]   char_cnt_nxt, res_data_nxt;
  logic          err_nxt;

  logic          fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [16:0]   fifo_head;
  logic          head_last;
  logic [15:0]   head_data;

  assign {head_last, head_data} = fifo_head;
  assign s_ready   = !fifo_full;
  assign res_valid = (state == S_HOLD_RES);

  rnn_seq_fifo #(.WIDTH(17), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (s_valid && s_ready),
    .pop   (fifo_pop),
    .wdata ({s_last, s_data}),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_nxt    = state;
    elem_idx_nxt = elem_idx;
    seq_end_nxt  = seq_end;
    poll_cnt_nxt = poll_cnt;
    char_cnt_nxt = char_cnt;
    res_data_nxt = res_data;
    err_nxt      = err;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    rnn_read     = 1'b0;
    rnn_write    = 1'b0;
    rnn_addr     = 3'd0;
    rnn_wdata    = 32'd0;
    case (state)
      S_IDLE: if (enable) state_nxt = S_LOAD_ELEM;
      S_LOAD_ELEM: begin
        // An empty FIFO simply stalls here; the host may be slow.
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          rnn_write = 1'b1;
          rnn_addr  = 3'd1;
          rnn_wdata = {8'h00, elem_idx, head_data};
          if (elem_idx == LAST_IDX) begin
            seq_end_nxt  = head_last;
            elem_idx_nxt = 8'd0;
            state_nxt    = S_START;
          end else begin
            elem_idx_nxt = elem_idx + 8'd1;
          end
        end
      end
      S_START: begin
        rnn_write    = 1'b1;
        char_cnt_nxt = char_cnt + 16'd1;
        poll_cnt_nxt = '0;
        state_nxt    = S_WAIT_STEP;
      end
      S_WAIT_STEP: begin
        rnn_read = 1'b1;
        rnn_addr = 3'd1;
        if (rnn_rdata[0]) begin
          state_nxt = seq_end ? S_DENSE : S_LOAD_ELEM;
        end else if (poll_cnt == POLL_MAX) begin
          err_nxt   = 1'b1;
          state_nxt = S_ERROR;
        end else begin
          poll_cnt_nxt = poll_cnt + 1'b1;
        end
      end
      S_DENSE: begin
        rnn_write    = 1'b1;
        rnn_addr     = 3'd7;
        poll_cnt_nxt = '0;
        state_nxt    = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        rnn_read = 1'b1;
        if (rnn_rdata[0]) begin
          state_nxt = S_READ_RES;
        end else if (poll_cnt == POLL_MAX) begin
          err_nxt   = 1'b1;
          state_nxt = S_ERROR;
        end else begin
          poll_cnt_nxt = poll_cnt + 1'b1;
        end
      end
      S_READ_RES: begin
        // This read also sends the accelerator back to LOAD.
        rnn_read     = 1'b1;
        rnn_addr     = 3'd7;
        res_data_nxt = rnn_rdata[15:0];
        state_nxt    = S_HOLD_RES;
      end
      S_HOLD_RES: begin
        if (res_ready) begin
          char_cnt_nxt = 16'd0;
          seq_end_nxt  = 1'b0;
          state_nxt    = enable ? S_LOAD_ELEM : S_IDLE;
        end
      end
      S_ERROR: begin
        if (clr_err) begin
          fifo_flush   = 1'b1;
          err_nxt      = 1'b0;
          char_cnt_nxt = 16'd0;
          seq_end_nxt  = 1'b0;
          elem_idx_nxt = 8'd0;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      elem_idx <= 8'd0;
      seq_end  <= 1'b0;
      poll_cnt <= '0;
      char_cnt <= 16'd0;
      res_data <= 16'd0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      elem_idx <= elem_idx_nxt;
      seq_end  <= seq_end_nxt;
      poll_cnt <= poll_cnt_nxt;
      char_cnt <= char_cnt_nxt;
      res_data <= res_data_nxt;
      err      <= err_nxt;
    end
  end
endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// Bench for rnn_seq_ctrl: behavioural accelerator, access log and per-scenario checks.
module tb_rnn_seq_ctrl;
  localparam int EMB_LEN = 4, FIFO_DEPTH = 16, POLL_LIMIT = 1024;

  logic clk = 0, rst_n = 0, enable = 0, s_valid = 0, s_last = 0, res_ready = 0, clr_err = 0;
  logic [15:0] s_data = 0;
  logic s_ready, res_valid, err, rnn_read, rnn_write;
  logic [15:0] res_data, char_cnt;
  logic [2:0]  rnn_addr;
  logic [31:0] rnn_wdata, rnn_rdata;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  rnn_seq_ctrl #(.EMB_LEN(EMB_LEN), .FIFO_DEPTH(FIFO_DEPTH), .POLL_LIMIT(POLL_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .char_cnt(char_cnt), .err(err), .clr_err(clr_err),
    .rnn_read(rnn_read), .rnn_write(rnn_write), .rnn_addr(rnn_addr),
    .rnn_wdata(rnn_wdata), .rnn_rdata(rnn_rdata));

  // Accelerator model: step/dense take a programmable number of cycles.
  typedef enum {M_LOAD, M_STEP, M_DENSE, M_RES} mst_t;
  mst_t m_st;
  int m_cnt, step_lat = 2, dense_lat = 2;
  bit hang = 0;
  logic [15:0] m_res;
  logic [15:0] res_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= M_LOAD; m_cnt <= 0; m_res <= 16'h0;
    end else begin
      case (m_st)
        M_LOAD:
          if (rnn_write && rnn_addr == 3'd0) begin m_st <= M_STEP; m_cnt <= step_lat; end
          else if (rnn_write && rnn_addr == 3'd7) begin m_st <= M_DENSE; m_cnt <= dense_lat; end
        M_STEP:
          if (!hang) begin
            if (m_cnt <= 1) m_st <= M_LOAD; else m_cnt <= m_cnt - 1;
          end
        M_DENSE:
          if (m_cnt <= 1) begin
            m_st <= M_RES;
            if (res_q.size() > 0) m_res <= res_q.pop_front(); else m_res <= 16'hBAD0;
          end else m_cnt <= m_cnt - 1;
        default:
          if (rnn_read && rnn_addr == 3'd7) m_st <= M_LOAD;
      endcase
    end
  end

  assign rnn_rdata = (rnn_addr == 3'd1) ? {31'b0, m_st == M_LOAD} :
                     (rnn_addr == 3'd0) ? {31'b0, m_st == M_RES} :
                     (rnn_addr == 3'd7) ? {16'hA5A5, m_res} : 32'h0;

  // Access log sampled mid-cycle.
  typedef struct { int cyc; bit rd; logic [2:0] addr; logic [31:0] wd; } acc_t;
  acc_t acc_q[$];
  logic [15:0] cc_hist[$];
  int hand_cyc[$], push_cyc[$];
  logic [15:0] hand_dat[$], hand_cc[$];
  logic [34:0] exp_q[$];
  int cyc = 0, bus_viol = 0;

  always @(negedge clk) begin
    cc_hist.push_back(char_cnt);
    if (rnn_read || rnn_write) acc_q.push_back('{cyc, rnn_read, rnn_addr, rnn_wdata});
    else if (rnn_addr !== 3'd0 || rnn_wdata !== 32'd0) bus_viol++;
    if (rnn_read && rnn_write) bus_viol++;
    if (rst_n && res_valid && res_ready) begin
      hand_cyc.push_back(cyc); hand_dat.push_back(res_data); hand_cc.push_back(char_cnt);
    end
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add_char(input logic [15:0] v [EMB_LEN]);
    for (int i = 0; i < EMB_LEN; i++) exp_q.push_back({3'd1, 8'h00, 8'(i), v[i]});
    exp_q.push_back({3'd0, 32'h0});
  endfunction

  function automatic int write_diff();
    int k = 0;
    foreach (acc_q[i]) if (!acc_q[i].rd) begin
      if (k >= exp_q.size() || {acc_q[i].addr, acc_q[i].wd} !== exp_q[k]) return k;
      k++;
    end
    return (k == exp_q.size()) ? -1 : k;
  endfunction

  function automatic logic [34:0] write_at(input int k);
    int n = 0;
    foreach (acc_q[i]) if (!acc_q[i].rd) begin
      if (n == k) return {acc_q[i].addr, acc_q[i].wd};
      n++;
    end
    return 'x;
  endfunction

  function automatic int count_acc(input bit rd, input logic [2:0] a);
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i].rd == rd && acc_q[i].addr == a) n++;
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete(); exp_q.delete(); hand_cyc.delete(); hand_dat.delete();
    hand_cc.delete(); push_cyc.delete();
  endtask

  task automatic push(input logic [15:0] d, input logic l);
    int t = 0;
    while (!s_ready && t < 3000) begin tick(1); t++; end
    if (!s_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL push_wait: s_ready=%b, required 1", s_ready);
    end
    push_cyc.push_back(cyc);
    s_valid = 1; s_data = d; s_last = l;
    tick(1);
    s_valid = 0; s_last = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0; enable = 0; s_valid = 0; s_last = 0; res_ready = 0; clr_err = 0; hang = 0;
    res_q.delete();
    tick(3);
    rst_n = 1;
    tick(1);
    clear_logs();
  endtask

  task automatic test_reset();
    int t = 0;
    logic [71:0] got, want;
    apply_reset();
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    n_cmp++; if ({res_valid, err} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b want 00", {res_valid, err}); end
    n_cmp++; if ({res_data, char_cnt} !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", {res_data, char_cnt}); end
    n_cmp++; if ({rnn_read, rnn_write, rnn_addr, rnn_wdata} !== 37'h0) begin
      n_bad++; $display("FAIL rst_bus: got %h want 0", {rnn_read, rnn_write, rnn_addr, rnn_wdata}); end
    hang = 1; step_lat = 3; enable = 1;
    for (int i = 0; i < EMB_LEN; i++) push(16'($urandom), 1'b0);
    while (!(rnn_read && rnn_addr == 3'd1) && t < 200) begin tick(1); t++; end
    tick(4);
    n_cmp++; if (!(rnn_read && rnn_addr == 3'd1) || char_cnt !== 16'd1) begin
      n_bad++; $display("FAIL rst_reach_poll: read=%b addr=%0d cnt=%0d want 1/1/1", rnn_read, rnn_addr, char_cnt); end
    @(negedge clk);
    rst_n = 0;
    #1;
    got  = {s_ready, res_valid, err, res_data, char_cnt, rnn_read, rnn_write, rnn_addr, rnn_wdata};
    want = '0; want[71] = 1'b1;
    n_cmp++; if (got !== want) begin n_bad++; $display("FAIL rst_async: got %h want %h", got, want); end
    apply_reset();
  endtask

  task automatic test_single_char();
    logic [15:0] v [EMB_LEN];
    int t = 0, hold, j = -1, ph = 0;
    bit stable = 1, ord_ok = 1;
    clear_logs();
    v = '{16'h0100, 16'h0080, 16'hFF00, 16'h0000};
    add_char(v); exp_q.push_back({3'd7, 32'h0});
    step_lat = $urandom_range(1, 4); dense_lat = $urandom_range(1, 4);
    res_q.push_back(16'hFE80);
    enable = 1; res_ready = 0;
    for (int i = 0; i < EMB_LEN; i++) push(v[i], i == EMB_LEN - 1);
    while (!res_valid && t < 500) begin tick(1); t++; end
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL single_res_valid: got %b want 1", res_valid); end
    n_cmp++; if (res_data !== 16'hFE80) begin n_bad++; $display("FAIL single_res_data: got %h want fe80", res_data); end
    n_cmp++; if (char_cnt !== 16'd1) begin n_bad++; $display("FAIL single_char_cnt: got %0d want 1", char_cnt); end
    hold = $urandom_range(3, 8);
    repeat (hold) begin tick(1); if (res_valid !== 1'b1 || res_data !== 16'hFE80) stable = 0; end
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL single_hold: valid=%b data=%h want 1/fe80", res_valid, res_data); end
    res_ready = 1; tick(1); res_ready = 0;
    n_cmp++; if ({res_valid, char_cnt} !== 17'h0) begin
      n_bad++; $display("FAIL single_handoff: valid=%b cnt=%0d want 0/0", res_valid, char_cnt); end
    t = write_diff();
    n_cmp++; if (t !== -1) begin n_bad++; $display("FAIL single_writes: #%0d got %h want %h", t, write_at(t), exp_q[t]); end
    foreach (acc_q[i]) begin
      if (!acc_q[i].rd && acc_q[i].addr == 3'd0) begin ph = 1; if (j < 0) j = i; end
      else if (!acc_q[i].rd && acc_q[i].addr == 3'd7) ph = 2;
      else if (acc_q[i].rd) begin
        if (ph == 0 || (ph == 1 && acc_q[i].addr != 3'd1) || (ph == 2 && acc_q[i].addr == 3'd1)) ord_ok = 0;
        if (acc_q[i].addr == 3'd7) ph = 3;
      end
    end
    n_cmp++; if (!ord_ok) begin n_bad++; $display("FAIL single_order: got misordered reads, want step polls then result polls"); end
    n_cmp++; if (j < 0 || j + 1 >= acc_q.size() || !acc_q[j+1].rd || acc_q[j+1].addr != 3'd1 || acc_q[j+1].cyc != acc_q[j].cyc + 1) begin
      n_bad++; $display("FAIL single_first_poll: start at index %0d, want addr-1 read next cycle", j); end
    n_cmp++; if (count_acc(1, 3'd1) !== step_lat + 1 || count_acc(1, 3'd0) !== dense_lat + 1) begin
      n_bad++; $display("FAIL single_polls: got %0d/%0d want %0d/%0d", count_acc(1, 3'd1), count_acc(1, 3'd0), step_lat + 1, dense_lat + 1); end
    n_cmp++; if (count_acc(1, 3'd7) !== 1) begin n_bad++; $display("FAIL single_res_read: got %0d want 1", count_acc(1, 3'd7)); end
  endtask

  task automatic test_starved();
    logic [15:0] v [EMB_LEN];
    logic [15:0] r;
    int t = 0, k = 0;
    bit order_ok = 1;
    clear_logs();
    step_lat = $urandom_range(1, 5); dense_lat = $urandom_range(1, 5);
    r = 16'($urandom); res_q.push_back(r);
    enable = 1; res_ready = 0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < EMB_LEN; i++) begin
        v[i] = 16'($urandom);
        push(v[i], (i == EMB_LEN - 1) ? (c == 2) : 1'($urandom_range(0, 1)));
        tick($urandom_range(0, 6));
      end
      add_char(v);
    end
    exp_q.push_back({3'd7, 32'h0});
    while (!res_valid && t < 800) begin tick(1); t++; end
    n_cmp++; if (res_valid !== 1'b1 || res_data !== r) begin
      n_bad++; $display("FAIL starved_result: valid=%b data=%h want 1/%h", res_valid, res_data, r); end
    n_cmp++; if (char_cnt !== 16'd3) begin n_bad++; $display("FAIL starved_char_cnt: got %0d want 3", char_cnt); end
    t = write_diff();
    n_cmp++; if (t !== -1) begin n_bad++; $display("FAIL starved_writes: #%0d got %h want %h", t, write_at(t), exp_q[t]); end
    n_cmp++; if (count_acc(0, 3'd7) !== 1) begin n_bad++; $display("FAIL starved_dense: got %0d want 1", count_acc(0, 3'd7)); end
    foreach (acc_q[i]) if (!acc_q[i].rd && acc_q[i].addr == 3'd1) begin
      if (k < push_cyc.size() && acc_q[i].cyc < push_cyc[k] + 1) order_ok = 0;
      k++;
    end
    n_cmp++; if (!order_ok) begin n_bad++; $display("FAIL starved_early_write: got write before its element arrived, want none"); end
    res_ready = 1; tick(1); res_ready = 0;
  endtask

  task automatic test_fifo_full();
    logic [15:0] v [EMB_LEN];
    logic [15:0] w [16];
    int t = 0, waited = 0;
    clear_logs();
    hang = 1; step_lat = 2; dense_lat = 2; enable = 1; res_ready = 0;
    for (int i = 0; i < EMB_LEN; i++) begin v[i] = 16'($urandom); push(v[i], 1'b0); end
    add_char(v);
    while (!(rnn_read && rnn_addr == 3'd1) && t < 200) begin tick(1); t++; end
    n_cmp++; if (!(rnn_read && rnn_addr == 3'd1)) begin n_bad++; $display("FAIL full_stall: read=%b addr=%0d want 1/1", rnn_read, rnn_addr); end
    for (int k = 0; k < 16; k++) begin
      w[k] = 16'($urandom);
      if (!s_ready) waited++;
      push(w[k], k == 15);
    end
    n_cmp++; if (waited !== 0) begin n_bad++; $display("FAIL full_early_block: got %0d blocked pushes want 0", waited); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL full_s_ready: got %b want 0", s_ready); end
    s_valid = 1; s_data = 16'hDEAD; s_last = 1; tick(1); s_valid = 0; s_last = 0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < EMB_LEN; i++) v[i] = w[c*EMB_LEN + i];
      add_char(v);
    end
    exp_q.push_back({3'd7, 32'h0});
    res_q.push_back(16'($urandom));
    hang = 0; res_ready = 1; t = 0;
    while (hand_cyc.size() == 0 && t < 800) begin tick(1); t++; end
    res_ready = 0; tick(20);
    n_cmp++; if (hand_cc.size() != 1 || hand_cc[0] !== 16'd5) begin
      n_bad++; $display("FAIL full_char_cnt: got %0d handoffs want 1 with count 5", hand_cc.size()); end
    t = write_diff();
    n_cmp++; if (t !== -1) begin n_bad++; $display("FAIL full_writes: #%0d got %h want %h", t, write_at(t), exp_q[t]); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL full_drained: s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_timeout();
    int t = 0, n0;
    clear_logs();
    hang = 1; step_lat = 2; enable = 1;
    for (int i = 0; i < EMB_LEN; i++) push(16'($urandom), 1'b0);
    while (!err && t < 3000) begin tick(1); t++; end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", err); end
    n_cmp++; if (count_acc(1, 3'd1) !== POLL_LIMIT) begin
      n_bad++; $display("FAIL timeout_polls: got %0d want %0d", count_acc(1, 3'd1), POLL_LIMIT); end
    n0 = acc_q.size();
    push(16'h1111, 1'b0); push(16'h2222, 1'b0);
    tick(10);
    n_cmp++; if (acc_q.size() !== n0 || err !== 1'b1) begin
      n_bad++; $display("FAIL timeout_quiet: got %0d accesses err=%b want 0/1", acc_q.size() - n0, err); end
    enable = 0; clr_err = 1; tick(1); clr_err = 0;
    n_cmp++; if ({err, char_cnt} !== 17'h0) begin n_bad++; $display("FAIL timeout_clear: err=%b cnt=%0d want 0/0", err, char_cnt); end
    hang = 0; tick(5); enable = 1; tick(10);
    n_cmp++; if (acc_q.size() !== n0) begin n_bad++; $display("FAIL timeout_flush: got %0d accesses want 0", acc_q.size() - n0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v [EMB_LEN];
    logic [15:0] ra, rb, b0;
    logic [35:0] nxt;
    int t = 0;
    clear_logs();
    enable = 0; res_ready = 1;
    step_lat = $urandom_range(1, 4); dense_lat = $urandom_range(1, 4);
    ra = 16'($urandom); rb = 16'($urandom);
    res_q.push_back(ra); res_q.push_back(rb);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < EMB_LEN; i++) begin
        v[i] = 16'($urandom);
        push(v[i], (i == EMB_LEN - 1) && (c != 1));
      end
      if (c == 1) b0 = v[0];
      add_char(v);
      if (c != 1) exp_q.push_back({3'd7, 32'h0});
    end
    enable = 1;
    while (hand_cyc.size() < 2 && t < 1000) begin tick(1); t++; end
    res_ready = 0;
    n_cmp++; if (hand_cyc.size() !== 2) begin n_bad++; $display("FAIL b2b_handoffs: got %0d want 2", hand_cyc.size()); end
    else begin
      n_cmp++; if ({hand_dat[0], hand_dat[1]} !== {ra, rb}) begin
        n_bad++; $display("FAIL b2b_results: got %h %h want %h %h", hand_dat[0], hand_dat[1], ra, rb); end
      n_cmp++; if ({hand_cc[0], hand_cc[1]} !== {16'd1, 16'd2}) begin
        n_bad++; $display("FAIL b2b_char_cnt: got %0d %0d want 1 2", hand_cc[0], hand_cc[1]); end
      nxt = 'x;
      foreach (acc_q[i]) if (acc_q[i].cyc == hand_cyc[0] + 1) nxt = {acc_q[i].rd, acc_q[i].addr, acc_q[i].wd};
      n_cmp++; if (nxt !== {1'b0, 3'd1, 16'h0000, b0}) begin
        n_bad++; $display("FAIL b2b_first_write: got %h want %h", nxt, {1'b0, 3'd1, 16'h0000, b0}); end
      n_cmp++; if (cc_hist[hand_cyc[0] + 1] !== 16'd0) begin
        n_bad++; $display("FAIL b2b_cnt_restart: got %0d want 0", cc_hist[hand_cyc[0] + 1]); end
    end
    t = write_diff();
    n_cmp++; if (t !== -1) begin n_bad++; $display("FAIL b2b_writes: #%0d got %h want %h", t, write_at(t), exp_q[t]); end
  endtask

  task automatic test_bus_rules();
    n_cmp++; if (bus_viol !== 0) begin n_bad++; $display("FAIL bus_rules: got %0d violations want 0", bus_viol); end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_starved();
    test_fifo_full();
    test_timeout();
    test_back_to_back();
    test_bus_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
